// File: rtl/fetch_pkg.sv
// Shared types and instruction-field positions for the dual-issue fetch queue.
package fetch_pkg;

    localparam int FQ_XLEN  = 32;
    localparam int OPC_LSB  = 2;
    localparam int OPC_MSB  = 6;
    localparam int F7B5_BIT = 30;
    localparam int F3_LSB   = 12;
    localparam int F3_MSB   = 14;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fq_field_extract.sv
// Per-lane decode field extraction; all outputs forced to zero for an invalid lane.
module fq_field_extract #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] inst,
    input  logic            valid,
    output logic [4:0]      op_code,
    output logic [3:0]      sub_op_code,
    output logic            illegal
);
    import fetch_pkg::*;

    logic unused_inst_s;
    assign unused_inst_s = ^inst;

    // Field slicing gated by lane valid
    always_comb begin
        op_code     = 5'd0;
        sub_op_code = 4'd0;
        illegal     = 1'b0;
        if (valid) begin
            op_code     = inst[OPC_MSB:OPC_LSB];
            sub_op_code = {inst[F7B5_BIT], inst[F3_MSB:F3_LSB]};
            illegal     = (inst[1:0] != 2'b11);
        end else begin
            op_code     = 5'd0;
            sub_op_code = 4'd0;
            illegal     = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue circular instruction queue feeding two decode lanes.
// Optional zero-latency empty-queue bypass: define FETCH_QUEUE_BYPASS_EN. XLEN must equal FQ_XLEN.
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            in_two,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_inst0,
    input  logic [XLEN-1:0] in_inst1,
    output logic            in_ready,
    input  logic [1:0]      deq_count,
    output logic            out_valid0,
    output logic            out_valid1,
    output logic [XLEN-1:0] out_pc0,
    output logic [XLEN-1:0] out_pc1,
    output logic [XLEN-1:0] out_inst0,
    output logic [XLEN-1:0] out_inst1,
    output logic [4:0]      op_code0,
    output logic [4:0]      op_code1,
    output logic [3:0]      sub_op_code0,
    output logic [3:0]      sub_op_code1,
    output logic            illegal0,
    output logic            illegal1
);
    import fetch_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t       mem_q [DEPTH];
    fq_entry_t       mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [1:0]      deq_eff_s, n_in_s, avail_s, pop_s, skip_s;
    logic            bypass_s, push_s;
    logic [PW-1:0]   wr_ptr1_s, rd_ptr1_s;
    logic            v0_s, v1_s;
    logic [XLEN-1:0] pc0_s, pc1_s, inst0_s, inst1_s;

    assign in_ready  = (count_q <= CW'(DEPTH - 2));
    assign wr_ptr1_s = wr_ptr_q + PW'(1);
    assign rd_ptr1_s = rd_ptr_q + PW'(1);

    // Accept/pop arbitration; pop is clamped to what the lanes actually show
    always_comb begin
        deq_eff_s = (deq_count == 2'd3) ? 2'd2 : deq_count;
        n_in_s    = in_two ? 2'd2 : 2'd1;
        bypass_s  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_s  = (count_q == CW'(0)) && in_valid && !flush && !rst;
`endif
        if (bypass_s) begin
            avail_s = n_in_s;
        end else if (count_q >= CW'(2)) begin
            avail_s = 2'd2;
        end else begin
            avail_s = count_q[1:0];
        end
        pop_s  = (deq_eff_s < avail_s) ? deq_eff_s : avail_s;
        push_s = in_valid && in_ready;
        // Bypassed entries consumed this cycle never touch storage
        skip_s = bypass_s ? pop_s : 2'd0;
    end

    // Next-state for storage, pointers and occupancy; flush wins over everything
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = PW'(0);
            wr_ptr_d = PW'(0);
            count_d  = CW'(0);
        end else begin
            if (push_s) begin
                if (skip_s == 2'd0) begin
                    mem_d[wr_ptr_q].pc   = in_pc;
                    mem_d[wr_ptr_q].inst = in_inst0;
                end else begin
                    mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
                end
                if (in_two && (skip_s != 2'd2)) begin
                    mem_d[wr_ptr1_s].pc   = in_pc + XLEN'(4);
                    mem_d[wr_ptr1_s].inst = in_inst1;
                end else begin
                    mem_d[wr_ptr1_s] = mem_q[wr_ptr1_s];
                end
                wr_ptr_d = wr_ptr_q + PW'(n_in_s);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            rd_ptr_d = rd_ptr_q + PW'(pop_s);
            count_d  = count_q + (push_s ? CW'(n_in_s) : CW'(0)) - CW'(pop_s);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= PW'(0);
            wr_ptr_q <= PW'(0);
            count_q  <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= fq_entry_t'(0);
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Lane view: storage at rd_ptr/rd_ptr+1, or the live input group when bypassing
    always_comb begin
        if (bypass_s) begin
            v0_s    = 1'b1;
            v1_s    = in_two;
            pc0_s   = in_pc;
            pc1_s   = in_pc + XLEN'(4);
            inst0_s = in_inst0;
            inst1_s = in_inst1;
        end else begin
            v0_s    = (count_q != CW'(0));
            v1_s    = (count_q >= CW'(2));
            pc0_s   = mem_q[rd_ptr_q].pc;
            pc1_s   = mem_q[rd_ptr1_s].pc;
            inst0_s = mem_q[rd_ptr_q].inst;
            inst1_s = mem_q[rd_ptr1_s].inst;
        end
        out_valid0 = v0_s;
        out_valid1 = v1_s;
        out_pc0    = v0_s ? pc0_s   : XLEN'(0);
        out_inst0  = v0_s ? inst0_s : XLEN'(0);
        out_pc1    = v1_s ? pc1_s   : XLEN'(0);
        out_inst1  = v1_s ? inst1_s : XLEN'(0);
    end

    fq_field_extract #(.XLEN(XLEN)) u_fx0 (
        .inst        (out_inst0),
        .valid       (out_valid0),
        .op_code     (op_code0),
        .sub_op_code (sub_op_code0),
        .illegal     (illegal0)
    );

    fq_field_extract #(.XLEN(XLEN)) u_fx1 (
        .inst        (out_inst1),
        .valid       (out_valid1),
        .op_code     (op_code1),
        .sub_op_code (sub_op_code1),
        .illegal     (illegal1)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default build, 1-cycle latency).
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_two;
    logic [31:0] in_pc;
    logic [31:0] in_inst0;
    logic [31:0] in_inst1;
    logic        in_ready;
    logic [1:0]  deq_count;
    logic        out_valid0, out_valid1;
    logic [31:0] out_pc0, out_pc1, out_inst0, out_inst1;
    logic [4:0]  op_code0, op_code1;
    logic [3:0]  sub_op_code0, sub_op_code1;
    logic        illegal0, illegal1;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    fetch_queue #(.DEPTH(8), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_two       (in_two),
        .in_pc        (in_pc),
        .in_inst0     (in_inst0),
        .in_inst1     (in_inst1),
        .in_ready     (in_ready),
        .deq_count    (deq_count),
        .out_valid0   (out_valid0),
        .out_valid1   (out_valid1),
        .out_pc0      (out_pc0),
        .out_pc1      (out_pc1),
        .out_inst0    (out_inst0),
        .out_inst1    (out_inst1),
        .op_code0     (op_code0),
        .op_code1     (op_code1),
        .sub_op_code0 (sub_op_code0),
        .sub_op_code1 (sub_op_code1),
        .illegal0     (illegal0),
        .illegal1     (illegal1)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            failures_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_two    = 1'b0;
        in_pc     = 32'h0;
        in_inst0  = 32'h0;
        in_inst1  = 32'h0;
        deq_count = 2'd0;
    endtask

    task automatic push_group(input logic two, input logic [31:0] pc,
                              input logic [31:0] i0, input logic [31:0] i1);
        in_valid = 1'b1;
        in_two   = two;
        in_pc    = pc;
        in_inst0 = i0;
        in_inst1 = i1;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] nxt_pc;

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        check_val("rst_valid0", {63'd0, out_valid0}, 64'd0);
        check_val("rst_valid1", {63'd0, out_valid1}, 64'd0);
        check_val("rst_pc0",    {32'd0, out_pc0},    64'd0);
        check_val("rst_op0",    {59'd0, op_code0},   64'd0);
        check_val("rst_ready",  {63'd0, in_ready},   64'd1);
        rst = 1'b0;
        tick();

        // Single push, visible next cycle
        push_group(1'b0, 32'h100, 32'h00500093, 32'h0);
        tick();
        idle_inputs();
        check_val("single_valid0", {63'd0, out_valid0},   64'd1);
        check_val("single_valid1", {63'd0, out_valid1},   64'd0);
        check_val("single_pc0",    {32'd0, out_pc0},      64'h100);
        check_val("single_inst0",  {32'd0, out_inst0},    64'h00500093);
        check_val("single_op0",    {59'd0, op_code0},     64'h04);
        check_val("single_sub0",   {60'd0, sub_op_code0}, 64'h0);
        check_val("single_ill0",   {63'd0, illegal0},     64'd0);
        deq_count = 2'd1;
        tick();
        idle_inputs();
        check_val("single_pop_valid0", {63'd0, out_valid0}, 64'd0);

        // Dual push then dual pop
        push_group(1'b1, 32'h200, 32'h00500093, 32'h40208133);
        tick();
        idle_inputs();
        check_val("dual_valid1", {63'd0, out_valid1},   64'd1);
        check_val("dual_pc0",    {32'd0, out_pc0},      64'h200);
        check_val("dual_pc1",    {32'd0, out_pc1},      64'h204);
        check_val("dual_op1",    {59'd0, op_code1},     64'h0C);
        check_val("dual_sub1",   {60'd0, sub_op_code1}, 64'h8);
        check_val("dual_inst1",  {32'd0, out_inst1},    64'h40208133);
        deq_count = 2'd2;
        tick();
        idle_inputs();
        check_val("dual_pop_valid0", {63'd0, out_valid0}, 64'd0);
        check_val("dual_pop_count",  {60'd0, dut.count_q}, 64'd0);

        // Fill to full with four dual pushes, then a dropped fifth
        for (int g = 0; g < 4; g++) begin
            push_group(1'b1, 32'h300 + 32'(g * 8), 32'h00000013, 32'h00000033);
            tick();
            idle_inputs();
            if (g == 2) begin
                check_val("fill3_count", {60'd0, dut.count_q}, 64'd6);
                check_val("fill3_ready", {63'd0, in_ready},    64'd1);
            end
        end
        check_val("full_count", {60'd0, dut.count_q}, 64'd8);
        check_val("full_ready", {63'd0, in_ready},    64'd0);
        push_group(1'b1, 32'h900, 32'h00000013, 32'h00000033);
        tick();
        idle_inputs();
        check_val("drop_count", {60'd0, dut.count_q}, 64'd8);
        check_val("drop_pc0",   {32'd0, out_pc0},     64'h300);
        check_val("drop_pc1",   {32'd0, out_pc1},     64'h304);

        // Down to 6, then steady push-2/pop-2 across the pointer wrap
        deq_count = 2'd2;
        tick();
        idle_inputs();
        check_val("six_pc0", {32'd0, out_pc0}, 64'h308);
        exp_pc = 32'h308;
        nxt_pc = 32'h320;
        for (int k = 0; k < 10; k++) begin
            push_group(1'b1, nxt_pc, 32'h00000013, 32'h00000033);
            deq_count = 2'd2;
            tick();
            idle_inputs();
            exp_pc = exp_pc + 32'd8;
            nxt_pc = nxt_pc + 32'd8;
            check_val($sformatf("wrap_pc0_%0d", k), {32'd0, out_pc0}, {32'd0, exp_pc});
            check_val($sformatf("wrap_pc1_%0d", k), {32'd0, out_pc1}, {32'd0, exp_pc + 32'd4});
            check_val($sformatf("wrap_cnt_%0d", k), {60'd0, dut.count_q}, 64'd6);
        end

        // Pop one to reach 5, then flush together with push and pop
        deq_count = 2'd1;
        tick();
        idle_inputs();
        check_val("five_count", {60'd0, dut.count_q}, 64'd5);
        flush = 1'b1;
        push_group(1'b1, 32'h500, 32'h00000013, 32'h00000033);
        deq_count = 2'd1;
        tick();
        idle_inputs();
        check_val("flush_count",  {60'd0, dut.count_q}, 64'd0);
        check_val("flush_valid0", {63'd0, out_valid0},  64'd0);
        check_val("flush_ready",  {63'd0, in_ready},    64'd1);
        check_val("flush_rdptr",  {61'd0, dut.rd_ptr_q}, 64'd0);
        check_val("flush_wrptr",  {61'd0, dut.wr_ptr_q}, 64'd0);

        // Illegal encoding, then over-pop of a single entry
        push_group(1'b0, 32'h600, 32'h00000000, 32'h0);
        tick();
        idle_inputs();
        check_val("ill_valid0", {63'd0, out_valid0}, 64'd1);
        check_val("ill_ill0",   {63'd0, illegal0},   64'd1);
        check_val("ill_ill1",   {63'd0, illegal1},   64'd0);
        check_val("ill_pc0",    {32'd0, out_pc0},    64'h600);
        deq_count = 2'd2;
        tick();
        idle_inputs();
        check_val("overpop_count",  {60'd0, dut.count_q}, 64'd0);
        check_val("overpop_valid0", {63'd0, out_valid0},  64'd0);
        check_val("overpop_ill0",   {63'd0, illegal0},    64'd0);
        check_val("overpop_rdptr",  {61'd0, dut.rd_ptr_q}, 64'd1);

        // Mid-operation reset discards contents
        push_group(1'b1, 32'h700, 32'h00000013, 32'h00000033);
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        check_val("midrst_valid0", {63'd0, out_valid0}, 64'd0);
        check_val("midrst_ready",  {63'd0, in_ready},   64'd1);
        tick();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
